// File: rtl/fwd_source_pipe_pkg.sv
// Shared widths and MEM/WB register field layout for the forwarding-source pipe.
package fwd_source_pipe_pkg;

    localparam int DEF_DBITS               = 32;
    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
    localparam int DEF_CNT_BITS            = 16;

    // Register field layout, LSB first: value | regno | wrtEn | valid | isLoad (MEM only)
    localparam int VALUE_LSB = 0;

    function automatic int regnoLsb(input int dbits);
        return dbits;
    endfunction

    function automatic int wrtEnBit(input int dbits, input int rbits);
        return dbits + rbits;
    endfunction

    function automatic int validBit(input int dbits, input int rbits);
        return dbits + rbits + 1;
    endfunction

    function automatic int isLoadBit(input int dbits, input int rbits);
        return dbits + rbits + 2;
    endfunction

    function automatic int wbRegWidth(input int dbits, input int rbits);
        return dbits + rbits + 2;
    endfunction

    function automatic int memRegWidth(input int dbits, input int rbits);
        return dbits + rbits + 3;
    endfunction

    // How the pipe registers advance on the next edge
    typedef enum logic [1:0] {
        ADV_NORMAL = 2'd0,
        ADV_HOLD   = 2'd1,
        ADV_BUBBLE = 2'd2
    } advMode_t;

endpackage

// File: rtl/fwd_source_pipe_if.sv
// EX-stage inputs, memory read data, pipe control and forwarding/regfile outputs.
interface fwd_source_pipe_if
    import fwd_source_pipe_pkg::*;
#(
    parameter int DBITS               = DEF_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int CNT_BITS            = DEF_CNT_BITS
);
    logic                           exValid;
    logic [DBITS-1:0]               exResult;
    logic [REG_INDEX_BIT_WIDTH-1:0] exDestRegno;
    logic                           exWrtEn;
    logic                           exIsLoad;
    logic [REG_INDEX_BIT_WIDTH-1:0] exRegno1;
    logic [REG_INDEX_BIT_WIDTH-1:0] exRegno2;
    logic [DBITS-1:0]               memRdData;
    logic                           extStall;
    logic                           flush;

    logic [DBITS-1:0]               memFwdValue;
    logic [REG_INDEX_BIT_WIDTH-1:0] memFwdRegno;
    logic                           memFwdWrtEn;
    logic [DBITS-1:0]               wbFwdValue;
    logic [REG_INDEX_BIT_WIDTH-1:0] wbFwdRegno;
    logic                           wbFwdWrtEn;
    logic                           rfWrtEn;
    logic [REG_INDEX_BIT_WIDTH-1:0] rfWrtIndex;
    logic [DBITS-1:0]               rfWrtData;
    logic                           loadUseStall;
    logic [CNT_BITS-1:0]            stallCount;

    modport master (
        output exValid, exResult, exDestRegno, exWrtEn, exIsLoad, exRegno1, exRegno2,
        output memRdData, extStall, flush,
        input  memFwdValue, memFwdRegno, memFwdWrtEn,
        input  wbFwdValue, wbFwdRegno, wbFwdWrtEn,
        input  rfWrtEn, rfWrtIndex, rfWrtData, loadUseStall, stallCount
    );

    modport slave (
        input  exValid, exResult, exDestRegno, exWrtEn, exIsLoad, exRegno1, exRegno2,
        input  memRdData, extStall, flush,
        output memFwdValue, memFwdRegno, memFwdWrtEn,
        output wbFwdValue, wbFwdRegno, wbFwdWrtEn,
        output rfWrtEn, rfWrtIndex, rfWrtData, loadUseStall, stallCount
    );

endinterface

// File: rtl/fwd_source_pipe_pipe_reg.sv
// Pipeline register with hold and bubble insertion; serves as both MEM and WB stage.
module fwd_source_pipe_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset beats hold; a bubble clears every field so nothing stale is forwarded
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/fwd_source_pipe.sv
// MEM/WB forwarding-source pipe: load-use hazard detection, stall counting and regfile write port.
module fwd_source_pipe
    import fwd_source_pipe_pkg::*;
#(
    parameter int DBITS               = DEF_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int CNT_BITS            = DEF_CNT_BITS
) (
    input logic               clk,
    input logic               reset,
    fwd_source_pipe_if.slave  pipe
);

    localparam int RB         = REG_INDEX_BIT_WIDTH;
    localparam int MEMW       = memRegWidth(DBITS, RB);
    localparam int WBW        = wbRegWidth(DBITS, RB);
    localparam int REGNO_LSB  = regnoLsb(DBITS);
    localparam int WRTEN_BIT  = wrtEnBit(DBITS, RB);
    localparam int VALID_BIT  = validBit(DBITS, RB);
    localparam int ISLOAD_BIT = isLoadBit(DBITS, RB);

    logic [MEMW-1:0]     memD, memQ;
    logic [WBW-1:0]      wbD, wbQ;
    logic                memValid, memWrtEn, memIsLoad;
    logic [DBITS-1:0]    memValue;
    logic [RB-1:0]       memRegno;
    logic                wbValid, wbWrtEn;
    logic [DBITS-1:0]    wbValue;
    logic [RB-1:0]       wbRegno;
    logic                loadUseStall;
    logic                regHold, memBubble;
    advMode_t            advMode;
    logic [CNT_BITS-1:0] stallCount;

    assign memValue  = memQ[VALUE_LSB +: DBITS];
    assign memRegno  = memQ[REGNO_LSB +: RB];
    assign memWrtEn  = memQ[WRTEN_BIT];
    assign memValid  = memQ[VALID_BIT];
    assign memIsLoad = memQ[ISLOAD_BIT];

    assign wbValue   = wbQ[VALUE_LSB +: DBITS];
    assign wbRegno   = wbQ[REGNO_LSB +: RB];
    assign wbWrtEn   = wbQ[WRTEN_BIT];
    assign wbValid   = wbQ[VALID_BIT];

    // Every register, including index 0, is a real destination and can create a hazard
    assign loadUseStall = memValid & memWrtEn & memIsLoad & pipe.exValid
                        & ((memRegno == pipe.exRegno1) | (memRegno == pipe.exRegno2));

    // Advance priority: freeze, then bubble (load-use or flush share a single bubble), else flow
    always_comb begin
        advMode = ADV_NORMAL;
        if (pipe.extStall) begin
            advMode = ADV_HOLD;
        end else if (loadUseStall || pipe.flush) begin
            advMode = ADV_BUBBLE;
        end
    end

    assign regHold   = (advMode == ADV_HOLD);
    assign memBubble = (advMode == ADV_BUBBLE);

    // Pack the EX instruction into the MEM register layout
    always_comb begin
        memD = '0;
        memD[VALUE_LSB +: DBITS] = pipe.exResult;
        memD[REGNO_LSB +: RB]    = pipe.exDestRegno;
        memD[WRTEN_BIT]          = pipe.exWrtEn;
        memD[VALID_BIT]          = pipe.exValid;
        memD[ISLOAD_BIT]         = pipe.exIsLoad;
    end

    // WB takes MEM, swapping in memory read data for loads
    always_comb begin
        wbD = '0;
        wbD[VALUE_LSB +: DBITS] = memIsLoad ? pipe.memRdData : memValue;
        wbD[REGNO_LSB +: RB]    = memRegno;
        wbD[WRTEN_BIT]          = memWrtEn;
        wbD[VALID_BIT]          = memValid;
    end

    fwd_source_pipe_pipe_reg #(.WIDTH(MEMW)) uMemReg (
        .clk    (clk),
        .reset  (reset),
        .hold   (regHold),
        .bubble (memBubble),
        .d      (memD),
        .q      (memQ)
    );

    fwd_source_pipe_pipe_reg #(.WIDTH(WBW)) uWbReg (
        .clk    (clk),
        .reset  (reset),
        .hold   (regHold),
        .bubble (1'b0),
        .d      (wbD),
        .q      (wbQ)
    );

    // Saturating count of load-use stall cycles; frozen along with the pipe
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (!regHold && loadUseStall && (stallCount != '1)) begin
            stallCount <= stallCount + CNT_BITS'(1);
        end
    end

    assign pipe.memFwdValue  = memValue;
    assign pipe.memFwdRegno  = memRegno;
    assign pipe.memFwdWrtEn  = memValid & memWrtEn & ~memIsLoad;
    assign pipe.wbFwdValue   = wbValue;
    assign pipe.wbFwdRegno   = wbRegno;
    assign pipe.wbFwdWrtEn   = wbValid & wbWrtEn;
    assign pipe.rfWrtEn      = wbValid & wbWrtEn;
    assign pipe.rfWrtIndex   = wbRegno;
    assign pipe.rfWrtData    = wbValue;
    assign pipe.loadUseStall = loadUseStall;
    assign pipe.stallCount   = stallCount;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Self-checking bench for fwd_source_pipe: per-cycle vector table, regfile-write scoreboard,
// reset-during-freeze sequence and stall-counter saturation on a narrow-counter instance.
module tb_fwd_source_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fwd_source_pipe_if bus ();
    fwd_source_pipe_if #(.CNT_BITS(4)) sat ();

    fwd_source_pipe dut (
        .clk   (clk),
        .reset (rst),
        .pipe  (bus)
    );

    fwd_source_pipe #(.CNT_BITS(4)) uSat (
        .clk   (clk),
        .reset (rst),
        .pipe  (sat)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  regno;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];

    typedef struct {
        logic        exValid, exWrtEn, exIsLoad;
        logic [3:0]  dest, r1, r2;
        logic [31:0] result, rdData;
        logic        extStall, flush;
        logic        eStall, eMemWe;
        logic [3:0]  eMemReg;
        logic [31:0] eMemVal;
        logic        eWbWe;
        logic [3:0]  eWbReg;
        logic [31:0] eWbVal;
        logic [15:0] eCnt;
        logic        push;
        logic [3:0]  pReg;
        logic [31:0] pVal;
    } row_t;

    localparam int NROWS = 28;
    row_t rows[NROWS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(
        input logic exValid, input logic exWrtEn, input logic exIsLoad,
        input logic [3:0] dest, input logic [3:0] r1, input logic [3:0] r2,
        input logic [31:0] result, input logic [31:0] rdData,
        input logic extStall, input logic flush,
        input logic eStall, input logic eMemWe, input logic [3:0] eMemReg, input logic [31:0] eMemVal,
        input logic eWbWe, input logic [3:0] eWbReg, input logic [31:0] eWbVal,
        input logic [15:0] eCnt,
        input logic push, input logic [3:0] pReg, input logic [31:0] pVal);
        row_t r;
        r.exValid = exValid; r.exWrtEn = exWrtEn; r.exIsLoad = exIsLoad;
        r.dest = dest; r.r1 = r1; r.r2 = r2; r.result = result; r.rdData = rdData;
        r.extStall = extStall; r.flush = flush;
        r.eStall = eStall; r.eMemWe = eMemWe; r.eMemReg = eMemReg; r.eMemVal = eMemVal;
        r.eWbWe = eWbWe; r.eWbReg = eWbReg; r.eWbVal = eWbVal; r.eCnt = eCnt;
        r.push = push; r.pReg = pReg; r.pVal = pVal;
        return r;
    endfunction

    task automatic driveEx(input logic v, input logic we, input logic ld, input logic [3:0] dest,
                           input logic [3:0] r1, input logic [3:0] r2, input logic [31:0] res);
        bus.exValid = v; bus.exWrtEn = we; bus.exIsLoad = ld; bus.exDestRegno = dest;
        bus.exRegno1 = r1; bus.exRegno2 = r2; bus.exResult = res;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every committed regfile write (pipe not frozen, not in reset) pops one expectation
    always @(negedge clk) begin
        wr_t e;
        if (!rst && !bus.extStall && bus.rfWrtEn) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rf_write: unexpected write index %0d data 0x%0h, required no write",
                         bus.rfWrtIndex, bus.rfWrtData);
            end else begin
                e = expQ.pop_front();
                chk("rf_write_index", 32'(bus.rfWrtIndex), 32'(e.regno));
                chk("rf_write_data", bus.rfWrtData, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required $finish earlier");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        //             V  W  L  dst r1 r2  result        rdData        ext fl | stl mWe mReg mVal        wWe wReg wVal          cnt | push reg val
        rows[0]  = mk(1, 1, 0, 3,  1, 2,  32'h7,        32'h0,        0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        1,  1, 3,  32'h7);
        rows[0].eCnt = 0;
        rows[1]  = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  1,  3,   32'h7,      0,  0,   32'h0,        0,  0, 0,  32'h0);
        rows[2]  = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  3,   32'h7,        0,  0, 0,  32'h0);
        rows[3]  = mk(1, 1, 1, 5,  0, 0,  32'h100,      32'h0,        0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        0,  1, 5,  32'h1234);
        rows[4]  = mk(1, 1, 0, 6,  5, 0,  32'h55,       32'h1234,     0, 0,  1,  0,  0,   32'h0,      0,  0,   32'h0,        0,  0, 0,  32'h0);
        rows[5]  = mk(1, 1, 0, 6,  5, 0,  32'h55,       32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  5,   32'h1234,     1,  1, 6,  32'h55);
        rows[6]  = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  1,  6,   32'h55,     0,  0,   32'h0,        1,  0, 0,  32'h0);
        rows[7]  = mk(1, 1, 0, 8,  0, 0,  32'h88,       32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  6,   32'h55,       1,  1, 8,  32'h88);
        rows[8]  = mk(1, 1, 0, 4,  0, 0,  32'h44,       32'h0,        0, 1,  0,  1,  8,   32'h88,     0,  0,   32'h0,        1,  0, 0,  32'h0);
        rows[9]  = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  8,   32'h88,       1,  0, 0,  32'h0);
        rows[10] = mk(1, 1, 0, 1,  0, 0,  32'h6,        32'h0,        0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        1,  1, 1,  32'h6);
        rows[11] = mk(1, 1, 0, 2,  0, 0,  32'h9,        32'h0,        0, 0,  0,  1,  1,   32'h6,      0,  0,   32'h0,        1,  1, 2,  32'h9);
        rows[12] = mk(1, 1, 0, 7,  0, 0,  32'h77,       32'h0,        1, 0,  0,  1,  2,   32'h9,      1,  1,   32'h6,        1,  0, 0,  32'h0);
        rows[13] = mk(1, 1, 0, 7,  0, 0,  32'h77,       32'h0,        1, 0,  0,  1,  2,   32'h9,      1,  1,   32'h6,        1,  0, 0,  32'h0);
        rows[14] = mk(1, 1, 0, 7,  0, 0,  32'h77,       32'h0,        1, 0,  0,  1,  2,   32'h9,      1,  1,   32'h6,        1,  0, 0,  32'h0);
        rows[15] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  1,  2,   32'h9,      1,  1,   32'h6,        1,  0, 0,  32'h0);
        rows[16] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  2,   32'h9,        1,  0, 0,  32'h0);
        rows[17] = mk(1, 1, 1, 9,  0, 0,  32'h200,      32'h0,        0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        1,  1, 9,  32'hBEEF);
        rows[18] = mk(1, 1, 0, 10, 0, 9,  32'hA,        32'hBEEF,     0, 1,  1,  0,  0,   32'h0,      0,  0,   32'h0,        1,  0, 0,  32'h0);
        rows[19] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  9,   32'hBEEF,     2,  0, 0,  32'h0);
        rows[20] = mk(1, 1, 1, 0,  0, 0,  32'h300,      32'h0,        0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        2,  1, 0,  32'hC0C0);
        rows[21] = mk(1, 1, 0, 11, 0, 0,  32'hB,        32'hC0C0,     0, 0,  1,  0,  0,   32'h0,      0,  0,   32'h0,        2,  0, 0,  32'h0);
        rows[22] = mk(1, 1, 0, 11, 0, 0,  32'hB,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  0,   32'hC0C0,     3,  1, 11, 32'hB);
        rows[23] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  1,  11,  32'hB,      0,  0,   32'h0,        3,  0, 0,  32'h0);
        rows[24] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  11,  32'hB,        3,  0, 0,  32'h0);
        rows[25] = mk(1, 1, 1, 12, 0, 0,  32'h400,      32'h0,        0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        3,  1, 12, 32'hDD);
        rows[26] = mk(0, 0, 0, 0,  12, 12, 32'h0,       32'hDD,       0, 0,  0,  0,  0,   32'h0,      0,  0,   32'h0,        3,  0, 0,  32'h0);
        rows[27] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0,  0,  0,  0,   32'h0,      1,  12,  32'hDD,       3,  0, 0,  32'h0);

        driveEx(0, 0, 0, 0, 0, 0, 32'h0);
        bus.memRdData = '0; bus.extStall = 1'b0; bus.flush = 1'b0;
        sat.exValid = 1'b0; sat.exWrtEn = 1'b0; sat.exIsLoad = 1'b0; sat.exDestRegno = '0;
        sat.exRegno1 = '0; sat.exRegno2 = '0; sat.exResult = '0; sat.memRdData = '0;
        sat.extStall = 1'b0; sat.flush = 1'b0;

        // Reset with freeze asserted: reset must still clear everything
        rst = 1'b1;
        bus.extStall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.extStall = 1'b0;
        chk("reset memFwdWrtEn", 32'(bus.memFwdWrtEn), 32'h0);
        chk("reset wbFwdWrtEn", 32'(bus.wbFwdWrtEn), 32'h0);
        chk("reset rfWrtEn", 32'(bus.rfWrtEn), 32'h0);
        chk("reset stallCount", 32'(bus.stallCount), 32'h0);
        chk("reset memFwdValue", bus.memFwdValue, 32'h0);
        chk("reset wbFwdValue", bus.wbFwdValue, 32'h0);
        chk("reset loadUseStall", 32'(bus.loadUseStall), 32'h0);

        for (int i = 0; i < NROWS; i++) begin
            driveEx(rows[i].exValid, rows[i].exWrtEn, rows[i].exIsLoad, rows[i].dest,
                    rows[i].r1, rows[i].r2, rows[i].result);
            bus.memRdData = rows[i].rdData;
            bus.extStall  = rows[i].extStall;
            bus.flush     = rows[i].flush;
            if (rows[i].push) begin
                expQ.push_back({rows[i].pReg, rows[i].pVal});
            end
            #1;
            chk($sformatf("row%0d loadUseStall", i), 32'(bus.loadUseStall), 32'(rows[i].eStall));
            chk($sformatf("row%0d memFwdWrtEn", i), 32'(bus.memFwdWrtEn), 32'(rows[i].eMemWe));
            chk($sformatf("row%0d wbFwdWrtEn", i), 32'(bus.wbFwdWrtEn), 32'(rows[i].eWbWe));
            chk($sformatf("row%0d rfWrtEn", i), 32'(bus.rfWrtEn), 32'(rows[i].eWbWe));
            chk($sformatf("row%0d stallCount", i), 32'(bus.stallCount), 32'(rows[i].eCnt));
            if (rows[i].eMemWe) begin
                chk($sformatf("row%0d memFwdRegno", i), 32'(bus.memFwdRegno), 32'(rows[i].eMemReg));
                chk($sformatf("row%0d memFwdValue", i), bus.memFwdValue, rows[i].eMemVal);
            end
            if (rows[i].eWbWe) begin
                chk($sformatf("row%0d wbFwdRegno", i), 32'(bus.wbFwdRegno), 32'(rows[i].eWbReg));
                chk($sformatf("row%0d wbFwdValue", i), bus.wbFwdValue, rows[i].eWbVal);
            end
            nextCycle();
        end

        // Reset while frozen with valid MEM and WB: both are discarded, no write follows
        driveEx(1, 1, 0, 13, 0, 0, 32'h13);
        bus.memRdData = '0; bus.extStall = 1'b0; bus.flush = 1'b0;
        nextCycle();
        driveEx(1, 1, 0, 14, 0, 0, 32'h14);
        nextCycle();
        driveEx(0, 0, 0, 0, 0, 0, 32'h0);
        bus.extStall = 1'b1;
        #1;
        chk("prereset memFwdWrtEn", 32'(bus.memFwdWrtEn), 32'h1);
        chk("prereset memFwdRegno", 32'(bus.memFwdRegno), 32'd14);
        chk("prereset wbFwdWrtEn", 32'(bus.wbFwdWrtEn), 32'h1);
        chk("prereset wbFwdRegno", 32'(bus.wbFwdRegno), 32'd13);
        chk("prereset stallCount", 32'(bus.stallCount), 32'd3);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        chk("midreset memFwdWrtEn", 32'(bus.memFwdWrtEn), 32'h0);
        chk("midreset wbFwdWrtEn", 32'(bus.wbFwdWrtEn), 32'h0);
        chk("midreset rfWrtEn", 32'(bus.rfWrtEn), 32'h0);
        chk("midreset stallCount", 32'(bus.stallCount), 32'h0);
        chk("midreset memFwdRegno", 32'(bus.memFwdRegno), 32'h0);
        chk("midreset wbFwdRegno", 32'(bus.wbFwdRegno), 32'h0);
        bus.extStall = 1'b0;
        nextCycle();
        chk("postreset rfWrtEn", 32'(bus.rfWrtEn), 32'h0);

        // Saturation on the 4-bit counter instance: load, then a dependent consumer, repeated
        for (int i = 0; i < 20; i++) begin
            sat.exValid = 1'b1; sat.exWrtEn = 1'b1; sat.exIsLoad = 1'b1;
            sat.exDestRegno = 4'd5; sat.exRegno1 = 4'd0; sat.exRegno2 = 4'd0;
            nextCycle();
            sat.exIsLoad = 1'b0; sat.exDestRegno = 4'd6; sat.exRegno1 = 4'd5;
            #1;
            chk($sformatf("sat%0d loadUseStall", i), 32'(sat.loadUseStall), 32'h1);
            nextCycle();
            chk($sformatf("sat%0d stallCount", i), 32'(sat.stallCount), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        chk("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_source_pipe.md
FWD_SOURCE_PIPE -- requirements
Module: fwd_source_pipe

Interface
REQ-001 Parameters SHALL be: DBITS, 32, data width; REG_INDEX_BIT_WIDTH, 4, register index width; CNT_BITS, 16, stall-counter width.
REQ-002 Ports SHALL be:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- exValid  input  1  EX stage holds a real instruction.
- exResult  input  DBITS  EX ALU result.
- exDestRegno  input  REG_INDEX_BIT_WIDTH  EX destination register.
- exWrtEn  input  1  EX instruction writes a register.
- exIsLoad  input  1  EX instruction is a load.
- exRegno1 / exRegno2  input  REG_INDEX_BIT_WIDTH  source registers read by the EX instruction.
- memRdData  input  DBITS  data-memory read data, valid in the cycle a load occupies MEM.
- extStall  input  1  global freeze.
- flush  input  1  kill the EX instruction.
- memFwdValue / memFwdRegno / memFwdWrtEn  output  DBITS / REG_INDEX_BIT_WIDTH / 1  MEM-stage forwarding source.
- wbFwdValue / wbFwdRegno / wbFwdWrtEn  output  DBITS / REG_INDEX_BIT_WIDTH / 1  WB-stage forwarding source.
- rfWrtEn / rfWrtIndex / rfWrtData  output  1 / REG_INDEX_BIT_WIDTH / DBITS  regfile write port.
- loadUseStall  output  1  combinational request that upstream hold the EX instruction.
- stallCount  output  CNT_BITS  number of load-use stall cycles.

Function
REQ-003 MEM register SHALL hold valid, value, regno, wrtEn, isLoad; WB register SHALL hold valid, value, regno, wrtEn.
REQ-004 loadUseStall SHALL equal memValid & memWrtEn & memIsLoad & exValid & ((memRegno==exRegno1)|(memRegno==exRegno2)); all 16 registers are ordinary, with no hardwired zero.
REQ-005 memFwdWrtEn SHALL equal memValid & memWrtEn & ~memIsLoad; a load in MEM never forwards from MEM.
REQ-006 memFwdValue/memFwdRegno SHALL be the MEM register value/regno; wbFwd* SHALL be the WB register contents with wbFwdWrtEn = wbValid & wbWrtEn.
REQ-007 rfWrtEn/rfWrtIndex/rfWrtData SHALL equal wbFwdWrtEn/wbFwdRegno/wbFwdValue (same cycle, 0-cycle latency from WB).
REQ-008 Advance priority per edge: extStall (all state holds, stallCount holds) > loadUseStall > flush > normal.
REQ-009 On loadUseStall without extStall: MEM SHALL load a bubble (valid=0), WB SHALL take MEM, stallCount SHALL increment saturating at all-ones.
REQ-010 On flush without stall: MEM SHALL load a bubble; WB SHALL take MEM normally; older instructions complete.
REQ-011 Normal advance: MEM takes {exValid, exResult, exDestRegno, exWrtEn, exIsLoad}; WB takes MEM, with value = memRdData when memIsLoad else memValue.
REQ-012 Result latency SHALL be: ALU result forwardable from MEM 1 cycle after EX; load data forwardable from WB 1 cycle after the MEM cycle.
REQ-013 A simultaneous flush and loadUseStall SHALL produce a single bubble and count one stall cycle.
REQ-014 While extStall is held, rfWrtEn SHALL stay asserted if WB is valid; repeated identical writes are legal.

Reset
REQ-015 On reset, memValid, wbValid, all outputs' enables, values, regnos, and stallCount SHALL become 0 on the next edge, overriding extStall and stall inputs.
REQ-016 A reset asserted mid-stall SHALL discard in-flight MEM/WB instructions without a regfile write in the reset cycle's following edge.

Structure
REQ-017 Shared header Fwd.vh SHALL define default widths and the MEM/WB field bit offsets; Alu.vh and Decoder.vh are unchanged.
REQ-018 One sub-module pipe_reg (parameterised width, hold, bubble, reset) SHALL implement both MEM and WB registers; hazard logic and counter stay in the top.

Verification
REQ-019 ADD R3 result 7 (exValid=1, exWrtEn=1, exIsLoad=0) -> next cycle memFwdRegno=3, memFwdValue=7, memFwdWrtEn=1; following cycle wbFwd*=3/7/1 and rfWrtEn=1.
REQ-020 Load to R5, then consumer with exRegno1=5 -> loadUseStall=1 for one cycle, memFwdWrtEn=0, bubble enters MEM; memRdData=0x1234 appears at wbFwdValue with wbFwdRegno=5, stallCount=1.
REQ-021 flush with exValid=1, exDestRegno=4 -> MEM valid=0, memFwdWrtEn=0; previous MEM instruction still reaches WB.
REQ-022 extStall high 3 cycles with R2=9 in MEM, R1=6 in WB -> all forwarding outputs hold 2/9 and 1/6, stallCount unchanged.
REQ-023 Force 65536 load-use stalls -> stallCount saturates at 0xFFFF.
REQ-024 Reset asserted during extStall with valid MEM/WB -> after one edge all WrtEn outputs 0, stallCount 0.
